// File: rtl/mux_arbiter_2x1_if.sv
// Handshake and data bundle between two requesters and the shared 2:1 output channel.
interface mux_arbiter_2x1_if #(
    parameter int WIDTH = 8
);
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;

    modport master (
        output req_a, req_b, data_a, data_b,
        input  gnt_a, gnt_b, sel, out_data, out_valid
    );

    modport slave (
        input  req_a, req_b, data_a, data_b,
        output gnt_a, gnt_b, sel, out_data, out_valid
    );
endinterface

// File: rtl/mux_arbiter_2x1.sv
// Round-robin arbiter with bounded hold time driving a per-bit mux_2x1 datapath.
module mux_2x1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

module mux_arbiter_2x1 #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    mux_arbiter_2x1_if.slave   bus
);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    state_t         state, nxt;
    logic           last;      // 1 = B was served most recently
    logic [HW-1:0]  hold_cnt;
    logic           gnt_a, gnt_b, sel;
    logic           expired;

    assign expired = (hold_cnt == HOLD_LAST);

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_a && bus.req_b) nxt = last ? GRANT_A : GRANT_B;
                else if (bus.req_a)         nxt = GRANT_A;
                else if (bus.req_b)         nxt = GRANT_B;
            end
            GRANT_A: begin
                if (!bus.req_a)                nxt = bus.req_b ? GRANT_B : IDLE;
                else if (bus.req_b && expired) nxt = GRANT_B;
            end
            GRANT_B: begin
                if (!bus.req_b)                nxt = bus.req_a ? GRANT_A : IDLE;
                else if (bus.req_a && expired) nxt = GRANT_A;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            sel      <= 1'b0;
            hold_cnt <= '0;
            last     <= 1'b1;
        end else begin
            state <= nxt;
            gnt_a <= (nxt == GRANT_A);
            gnt_b <= (nxt == GRANT_B);
            sel   <= (nxt == GRANT_B);
            // Any grant entry, including a direct A<->B switch, restarts the hold window.
            if (nxt == IDLE) begin
                hold_cnt <= '0;
            end else if (nxt != state) begin
                hold_cnt <= '0;
                last     <= (nxt == GRANT_B);
            end else if (!expired) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign bus.gnt_a     = gnt_a;
    assign bus.gnt_b     = gnt_b;
    assign bus.sel       = sel;
    assign bus.out_valid = (gnt_a & bus.req_a) | (gnt_b & bus.req_b);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_2x1 u_mux (
            .a   (bus.data_a[i]),
            .b   (bus.data_b[i]),
            .sel (sel),
            .y   (bus.out_data[i])
        );
    end
endmodule

// File: doc/mux_arbiter_2x1.md
# mux_arbiter_2x1

Two-requester arbiter that shares one `mux_2x1` output channel between sources A and B. It grants the channel with registered, round-robin fairness and a bounded hold time. It drives the mux `sel` from its grant state and presents the selected word with a valid flag. It sits directly in front of the `mux_2x1` datapath, which it instantiates once per data bit, and owns all sequencing of that datapath.

## Interface
- `WIDTH`, default 8: data word width; one `mux_2x1` per bit.
- `MAX_HOLD`, default 4: maximum consecutive cycles one requester keeps the grant while the other is requesting; legal range ≥ 1.
- `clk`  input  1  sole clock, rising edge.
- `reset_n`  input  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `req_a`  input  1  requester A wants the channel (level).
- `req_b`  input  1  requester B wants the channel (level).
- `data_a`  input  WIDTH  requester A word.
- `data_b`  input  WIDTH  requester B word.
- `gnt_a`  output  1  A owns the channel (registered).
- `gnt_b`  output  1  B owns the channel (registered).
- `sel`  output  1  mux select: 0 = A, 1 = B (registered).
- `out_data`  output  WIDTH  `sel ? data_b : data_a`, combinational through `mux_2x1` instances.
- `out_valid`  output  1  `(gnt_a & req_a) | (gnt_b & req_b)`, combinational.

## Operation
- States: IDLE, GRANT_A, GRANT_B. `gnt_a` = (state==GRANT_A), `gnt_b` = (state==GRANT_B), `sel` = (state==GRANT_B). All three are state-register outputs. No output ever has both grants high.
- `last` register records the most recently granted requester. It is updated on every entry to a grant state.
- `hold_cnt` has width max(1, clog2(MAX_HOLD)). It clears to 0 on every entry to a grant state, including a switch A→B or B→A. It increments each cycle the FSM stays in a grant state and saturates at MAX_HOLD-1.
- IDLE transitions:
  - `req_a & req_b` → grant the requester that is not `last`.
  - Only `req_a` → GRANT_A.
  - Only `req_b` → GRANT_B.
  - Neither → stay in IDLE.
- GRANT_A transitions (GRANT_B is symmetric):
  - `!req_a & req_b` → GRANT_B directly, with no IDLE bubble.
  - `!req_a & !req_b` → IDLE.
  - `req_a & req_b & hold_cnt==MAX_HOLD-1` → GRANT_B (preemption).
  - Otherwise → stay and increment `hold_cnt`.
- An uncontended requester keeps the grant indefinitely. The `hold_cnt` saturation causes no preemption unless the other requester is asserting.
- MAX_HOLD=1: under continuous contention, grants alternate every cycle.
- A requester that deasserts while granted yields `out_valid`=0 in that same cycle. The grant drops at the next edge.
- `out_data` follows `sel` and the data inputs combinationally and is not gated by `out_valid`. Consumers qualify it with `out_valid`.

## Timing
- Reset (`reset_n`=0 at an edge): state=IDLE, `gnt_a`=`gnt_b`=`sel`=0, `hold_cnt`=0, `last`=B, so A wins the first tie. `out_valid`=0, and `out_data`=`data_a`.
- Reset overrides everything, including an active grant. The grant is lost at that edge, and no state is retained.
- Request-to-grant latency: requests sampled at edge k produce a grant visible after edge k, so a cycle-0 request yields a cycle-1 grant. Switch latency is also 1 edge.
- Under continuous contention, each requester holds for exactly MAX_HOLD cycles, then the other requester receives the grant at the next edge.
- Simultaneous first requests from IDLE are resolved by `last`. Deassert-and-reassert by the holder after a switch gets no priority over the other side.

## Test plan
- Reset, then `req_a`=1 only at cycle 0 → cycle 1: `gnt_a`=1, `sel`=0, `out_valid`=1, `out_data`=`data_a`. Hold `req_a` for 10 cycles → grant never changes.
- Reset, then `req_a`=`req_b`=1 continuously, MAX_HOLD=4 → grants go A for cycles 1–4, B for 5–8, A for 9–12; `sel` matches; never both high.
- A granted, `req_a` drops and `req_b`=1 in the same cycle → `out_valid`=0 that cycle; next cycle `gnt_b`=1, `sel`=1, no IDLE cycle.
- Tie from IDLE after B was last served → A granted. After A was last served and both return to idle, the next tie → B granted.
- `reset_n`=0 asserted mid-grant (B, `hold_cnt`=2) → after that edge all outputs are 0 and state is IDLE; with `req_b` held, B is regranted 1 cycle after reset releases, with `hold_cnt`=0.
- MAX_HOLD=1, both requesting, `data_a`=0x5A, `data_b`=0xA5 → `out_data` alternates 0x5A/0xA5 every cycle with `out_valid`=1.
